// File: rtl/stream_arb_pkg.sv
// Shared types for the stream arbiter: FSM states, output buffer depth and the
// default {last, data} buffer entry layout.
package stream_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int FIFO_DEPTH         = 2;
  localparam int DATA_WIDTH_DEFAULT = 128;

  typedef struct packed {
    logic                          last;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } arb_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output buffer. The head register drives the stream directly, so a
// beat pushed into an empty buffer is visible on the very next cycle.
module stream_skid_fifo
  import stream_arb_pkg::*;
#(
  parameter type entry_t = arb_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  entry_t     i_din,
  input  logic       i_ready,
  output entry_t     o_head,
  output logic       o_valid,
  output logic [1:0] o_count
);

  entry_t     r_head;
  entry_t     r_tail;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop = (r_count != 2'd0) && i_ready;

  // Head only moves on a push into an empty buffer or on a pop, keeping data stable while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_din;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            r_head <= i_din;
          end else if (i_push) begin
            r_tail  <= i_din;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_din;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter with burst lock feeding one AXI-Stream master through a
// 2-entry buffer. Optional counters: STREAM_ARB_PKT_CNT_EN.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_SRC    = 5,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int PTR_WIDTH  = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC-1:0]            src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
`ifdef STREAM_ARB_PKT_CNT_EN
  ,
  output logic [31:0]                   pkt_count,
  output logic [15:0]                   drop_count
`endif
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam logic [1:0] CNT_FULL = 2'(FIFO_DEPTH);

  arb_state_t           r_state, w_state_nxt;
  logic [PTR_WIDTH-1:0] r_grant, w_grant_nxt;
  logic [PTR_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_WIDTH-1:0] w_lock_idx, w_rr_idx, w_grant_inc;
  logic                 w_lock_hit, w_rr_hit, w_xfer, w_abandon, w_fifo_valid;
  logic [1:0]           w_count;
  entry_t               w_din, w_head;

  function automatic logic [PTR_WIDTH-1:0] wrap_add(input logic [PTR_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return PTR_WIDTH'(s);
  endfunction

  // Lock candidate: lowest-index source with a burst in progress
  always_comb begin
    w_lock_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      w_lock_idx = src_in_progress[i] ? PTR_WIDTH'(i) : w_lock_idx;
    end
    w_lock_hit = |src_in_progress;
  end

  // Round-robin candidate: first valid source at or after the pointer, wrapping
  always_comb begin
    w_rr_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_rr_idx = src_valid[wrap_add(r_rr_ptr, k)] ? wrap_add(r_rr_ptr, k) : w_rr_idx;
    end
    w_rr_hit = |src_valid;
  end

  // Ready decodes registers only, so no combinational path from valid or tready
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (r_state == ST_GRANT) && (r_grant == PTR_WIDTH'(i)) && (w_count != CNT_FULL);
    end
  end

  assign w_xfer      = src_valid[r_grant] && src_ready[r_grant];
  assign w_abandon   = (r_state == ST_GRANT) && !w_xfer && !src_valid[r_grant] && !src_in_progress[r_grant];
  assign w_grant_inc = wrap_add(r_grant, 1);

  // Next-state: arbitrate in IDLE, hold the grant until last beat or abandon
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_lock_hit) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_lock_idx;
        end else if (w_rr_hit) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_rr_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if ((w_xfer && src_last[r_grant]) || w_abandon) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_grant_inc;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign w_din.last = src_last[r_grant];
  assign w_din.data = src_data[r_grant*DATA_WIDTH +: DATA_WIDTH];

  stream_skid_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_xfer),
    .i_din   (w_din),
    .i_ready (m_axis_tready),
    .o_head  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign m_axis_tdata  = w_head.data;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tvalid = w_fifo_valid;

`ifdef STREAM_ARB_PKT_CNT_EN
  logic [31:0] r_pkt_count;
  logic [15:0] r_drop_count;

  // Packets counted on the popped tlast beat; drops saturate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count  <= 32'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_abandon && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed self-checking bench for stream_arbiter (5 sources, 128-bit beats).
module tb_stream_arbiter;

  logic         clk;
  logic         reset;
  logic [4:0]   src_valid, src_in_progress, src_last, src_ready;
  logic [639:0] src_data;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
`ifdef STREAM_ARB_PKT_CNT_EN
  logic [31:0]  pkt_count;
  logic [15:0]  drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  stream_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .src_valid       (src_valid),
    .src_in_progress (src_in_progress),
    .src_last        (src_last),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready)
`ifdef STREAM_ARB_PKT_CNT_EN
    ,
    .pkt_count       (pkt_count),
    .drop_count      (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid       = 5'b0;
    src_in_progress = 5'b0;
    src_last        = 5'b0;
  endtask

  task automatic set_data(input int i, input logic [127:0] v);
    src_data[i*128 +: 128] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    src_data      = '0;
    m_axis_tready = 1'b1;
    reset         = 1'b1;
    repeat (2) tick();
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    n_checks++; if (m_axis_tlast !== 1'b0) begin n_errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    n_checks++; if (m_axis_tdata !== 128'd0) begin n_errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    n_checks++; if (src_ready !== 5'b00000) begin n_errors++; $display("FAIL reset_ready: got %b want 00000", src_ready); end
    n_checks++; if (dut.r_rr_ptr !== 3'd0) begin n_errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
    n_checks++; if (dut.w_count !== 2'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", dut.w_count); end
    reset = 1'b0;
    tick();
    n_checks++; if (src_ready !== 5'b00000) begin n_errors++; $display("FAIL idle_ready: got %b want 00000", src_ready); end
  endtask

  task automatic test_single_beat();
    src_valid[2] = 1'b1;
    src_last[2]  = 1'b1;
    set_data(2, 128'hA5);
    tick();
    n_checks++; if (src_ready !== 5'b00100) begin n_errors++; $display("FAIL single_ready: got %b want 00100", src_ready); end
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_errors++; $display("FAIL single_early_tvalid: got %b want 0", m_axis_tvalid); end
    tick();
    clear_inputs();
    n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'hA5 || m_axis_tlast !== 1'b1) begin
      n_errors++; $display("FAIL single_beat: got v=%b d=%h l=%b want v=1 d=a5 l=1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    n_checks++; if (dut.r_rr_ptr !== 3'd3) begin n_errors++; $display("FAIL single_rr_ptr: got %0d want 3", dut.r_rr_ptr); end
    tick();
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_errors++; $display("FAIL single_drain: got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_round_robin();
    logic [4:0]   exp_rdy;
    logic [127:0] exp_d;
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) set_data(i, 128'h10 + 128'(i));
    src_valid = 5'b11111;
    src_last  = 5'b11111;
    for (int p = 0; p < 6; p++) begin
      exp_rdy = 5'b00001 << (p % 5);
      exp_d   = 128'h10 + 128'(p % 5);
      tick();
      n_checks++; if (src_ready !== exp_rdy) begin n_errors++; $display("FAIL rr_grant_%0d: got %b want %b", p, src_ready, exp_rdy); end
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== 1'b1) begin
        n_errors++; $display("FAIL rr_beat_%0d: got v=%b d=%h want v=1 d=%h", p, m_axis_tvalid, m_axis_tdata, exp_d); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst_lock();
    logic [127:0] exp_d;
    src_valid       = 5'b00011;
    src_in_progress = 5'b00010;
    src_last        = 5'b00001;
    set_data(0, 128'hC0);
    set_data(1, 128'hB1);
    tick();
    n_checks++; if (src_ready !== 5'b00010) begin n_errors++; $display("FAIL lock_grant: got %b want 00010", src_ready); end
    for (int k = 1; k <= 4; k++) begin
      exp_d = 128'hB0 + 128'(k);
      set_data(1, exp_d);
      src_last[1] = (k == 4);
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== (k == 4)) begin
        n_errors++; $display("FAIL lock_beat_%0d: got v=%b d=%h l=%b want d=%h", k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d); end
      if (k < 4) begin
        n_checks++; if (src_ready !== 5'b00010) begin n_errors++; $display("FAIL lock_hold_%0d: got %b want 00010", k, src_ready); end
      end
    end
    src_valid[1]       = 1'b0;
    src_in_progress[1] = 1'b0;
    src_last[1]        = 1'b0;
    tick();
    n_checks++; if (src_ready !== 5'b00001) begin n_errors++; $display("FAIL lock_next_grant: got %b want 00001", src_ready); end
    tick();
    clear_inputs();
    n_checks++; if (m_axis_tdata !== 128'hC0 || m_axis_tlast !== 1'b1) begin
      n_errors++; $display("FAIL lock_src0_beat: got d=%h l=%b want d=c0 l=1", m_axis_tdata, m_axis_tlast); end
    tick();
  endtask

  task automatic test_backpressure();
    m_axis_tready      = 1'b0;
    src_valid[4]       = 1'b1;
    src_in_progress[4] = 1'b1;
    set_data(4, 128'hD1);
    tick();
    n_checks++; if (src_ready !== 5'b10000) begin n_errors++; $display("FAIL bp_grant: got %b want 10000", src_ready); end
    tick();
    set_data(4, 128'hD2);
    n_checks++; if (src_ready !== 5'b10000 || m_axis_tdata !== 128'hD1) begin
      n_errors++; $display("FAIL bp_beat1: got r=%b d=%h want r=10000 d=d1", src_ready, m_axis_tdata); end
    tick();
    set_data(4, 128'hD3);
    n_checks++; if (src_ready !== 5'b00000) begin n_errors++; $display("FAIL bp_full_ready: got %b want 00000", src_ready); end
    n_checks++; if (dut.w_count !== 2'd2) begin n_errors++; $display("FAIL bp_full_count: got %0d want 2", dut.w_count); end
    tick();
    n_checks++; if (src_ready !== 5'b00000 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 128'hD1) begin
      n_errors++; $display("FAIL bp_stable: got r=%b v=%b d=%h want r=00000 v=1 d=d1", src_ready, m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    tick();
    n_checks++; if (m_axis_tdata !== 128'hD2 || src_ready !== 5'b10000) begin
      n_errors++; $display("FAIL bp_beat2: got d=%h r=%b want d=d2 r=10000", m_axis_tdata, src_ready); end
    tick();
    set_data(4, 128'hD4);
    src_last[4] = 1'b1;
    n_checks++; if (m_axis_tdata !== 128'hD3 || m_axis_tlast !== 1'b0) begin
      n_errors++; $display("FAIL bp_beat3: got d=%h l=%b want d=d3 l=0", m_axis_tdata, m_axis_tlast); end
    tick();
    clear_inputs();
    n_checks++; if (m_axis_tdata !== 128'hD4 || m_axis_tlast !== 1'b1) begin
      n_errors++; $display("FAIL bp_beat4: got d=%h l=%b want d=d4 l=1", m_axis_tdata, m_axis_tlast); end
    tick();
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_reset_midburst();
    m_axis_tready      = 1'b0;
    src_valid[2]       = 1'b1;
    src_in_progress[2] = 1'b1;
    set_data(2, 128'hE1);
    tick();
    tick();
    set_data(2, 128'hE2);
    tick();
    n_checks++; if (dut.w_count !== 2'd2) begin n_errors++; $display("FAIL mid_count_pre: got %0d want 2", dut.w_count); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0 || src_ready !== 5'b00000) begin
      n_errors++; $display("FAIL mid_async_drop: got v=%b r=%b want v=0 r=00000", m_axis_tvalid, src_ready); end
    n_checks++; if (dut.w_count !== 2'd0) begin n_errors++; $display("FAIL mid_count_post: got %0d want 0", dut.w_count); end
    clear_inputs();
    src_valid     = 5'b01100;
    src_last      = 5'b01100;
    set_data(2, 128'hF2);
    set_data(3, 128'hF3);
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_checks++; if (src_ready !== 5'b00100) begin n_errors++; $display("FAIL mid_first_grant: got %b want 00100", src_ready); end
    tick();
    clear_inputs();
    n_checks++; if (m_axis_tdata !== 128'hF2 || m_axis_tlast !== 1'b1) begin
      n_errors++; $display("FAIL mid_first_beat: got d=%h l=%b want d=f2 l=1", m_axis_tdata, m_axis_tlast); end
    tick();
  endtask

  task automatic test_abandon();
`ifdef STREAM_ARB_PKT_CNT_EN
    n_checks++; if (pkt_count !== 32'd1 || drop_count !== 16'd0) begin
      n_errors++; $display("FAIL cnt_pre: got pkt=%0d drop=%0d want pkt=1 drop=0", pkt_count, drop_count); end
`endif
    src_valid[3] = 1'b1;
    tick();
    n_checks++; if (src_ready !== 5'b01000) begin n_errors++; $display("FAIL drop_grant: got %b want 01000", src_ready); end
    src_valid[3] = 1'b0;
    tick();
    n_checks++; if (dut.r_rr_ptr !== 3'd4) begin n_errors++; $display("FAIL drop_rr_ptr: got %0d want 4", dut.r_rr_ptr); end
    n_checks++; if (m_axis_tvalid !== 1'b0 || src_ready !== 5'b00000) begin
      n_errors++; $display("FAIL drop_idle: got v=%b r=%b want v=0 r=00000", m_axis_tvalid, src_ready); end
`ifdef STREAM_ARB_PKT_CNT_EN
    n_checks++; if (pkt_count !== 32'd1 || drop_count !== 16'd1) begin
      n_errors++; $display("FAIL cnt_post: got pkt=%0d drop=%0d want pkt=1 drop=1", pkt_count, drop_count); end
`endif
  endtask

  task automatic test_wrap();
    src_valid = 5'b10001;
    src_last  = 5'b10001;
    set_data(4, 128'h44);
    set_data(0, 128'h40);
    tick();
    n_checks++; if (src_ready !== 5'b10000) begin n_errors++; $display("FAIL wrap_grant4: got %b want 10000", src_ready); end
    tick();
    n_checks++; if (m_axis_tdata !== 128'h44 || dut.r_rr_ptr !== 3'd0) begin
      n_errors++; $display("FAIL wrap_ptr: got d=%h rr=%0d want d=44 rr=0", m_axis_tdata, dut.r_rr_ptr); end
    tick();
    n_checks++; if (src_ready !== 5'b00001) begin n_errors++; $display("FAIL wrap_grant0: got %b want 00001", src_ready); end
    tick();
    clear_inputs();
    n_checks++; if (m_axis_tdata !== 128'h40 || dut.r_rr_ptr !== 3'd1) begin
      n_errors++; $display("FAIL wrap_beat0: got d=%h rr=%0d want d=40 rr=1", m_axis_tdata, dut.r_rr_ptr); end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    m_axis_tready = 1'b1;
    src_data      = '0;
    clear_inputs();
    test_reset();
    test_single_beat();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_reset_midburst();
    test_abandon();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
